// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - in-flight register write scoreboard gating issue on RAW hazards and counter saturation
module regfile_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [4:0]         issue_rs1,
  input  logic [4:0]         issue_rs2,
  input  logic               issue_use_rs1,
  input  logic               issue_use_rs2,
  input  logic [4:0]         issue_rd,
  input  logic               issue_wr,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic               flush,
  output logic [31:0]        busy,
  output logic [6:0]         inflight_total,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Entry 31 is never incremented, so it stays zero and X31 can never hazard.
  logic [CNT_W-1:0] cnt      [32];
  logic [CNT_W-1:0] cnt_next [32];

  logic raw_hazard;
  logic full_hazard;
  logic fire;
  logic any_inc;
  logic wb_hit;
  logic any_dec;
  logic wb_bad;

  always_comb begin
    raw_hazard  = (issue_use_rs1 && (cnt[issue_rs1] != '0)) ||
                  (issue_use_rs2 && (cnt[issue_rs2] != '0));
    full_hazard = issue_wr && (issue_rd != 5'd31) && (cnt[issue_rd] == CNT_MAX);
    issue_ready = !reset && !flush && !raw_hazard && !full_hazard;
    fire        = issue_valid && issue_ready;
    any_inc     = fire && issue_wr && (issue_rd != 5'd31);
    wb_hit      = wb_valid && (wb_rd != 5'd31) && !flush;
    any_dec     = wb_hit && (cnt[wb_rd] != '0);
    wb_bad      = wb_hit && (cnt[wb_rd] == '0);
  end

  always_comb begin
    for (int r = 0; r < 32; r++) begin
      cnt_next[r] = cnt[r];
      if (any_inc && (issue_rd == 5'(r)) && !(any_dec && (wb_rd == 5'(r))))
        cnt_next[r] = cnt[r] + CNT_W'(1);
      else if (any_dec && (wb_rd == 5'(r)) && !(any_inc && (issue_rd == 5'(r))))
        cnt_next[r] = cnt[r] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
      busy           <= '0;
      inflight_total <= '0;
      stall_cycles   <= '0;
      wb_err         <= 1'b0;
    end else begin
      if (flush) begin
        for (int r = 0; r < 32; r++) cnt[r] <= '0;
        busy           <= '0;
        inflight_total <= '0;
      end else begin
        for (int r = 0; r < 32; r++) begin
          cnt[r]  <= cnt_next[r];
          busy[r] <= (cnt_next[r] != '0);
        end
        inflight_total <= inflight_total + 7'(any_inc) - 7'(any_dec);
      end
      if (issue_valid && !issue_ready && !flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_W'(1);
      if (wb_bad)
        wb_err <= 1'b1;
    end
  end

endmodule
